// File: rtl/clockworks_if.sv
// Divided system clock and its conditioned reset, as seen by the core logic.
interface clockworks_if;
  logic clk;
  logic resetn;

  modport master (output clk, output resetn);
  modport slave  (input  clk, input  resetn);
endinterface

// File: rtl/clockworks.sv
// Board clock divider (power of two) with a synchronized, stretched
// active-low reset for the divided-clock domain.
module clockworks #(
  parameter int SLOW       = 19,
  parameter int RST_CYCLES = 16
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  logic [1:0]    sync;
  logic          rst_sync;
  logic [RW-1:0] rcnt;
  logic          rcnt_full;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) sync <= '0;
    else        sync <= {sync[0], 1'b1};
  end

  assign rst_sync  = sync[1];
  assign rcnt_full = (rcnt == RW'(RST_CYCLES));

  if (SLOW > 0) begin : g_div
    logic [SLOW:0] div;
    logic          clk_rise;
    logic          clk_fall;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)        div <= '0;
      else if (!rst_sync) div <= '0;
      else               div <= div + (SLOW + 1)'(1);
    end

    assign clk = div[SLOW];

    // Edge strobes decoded from the counter value just before it steps.
    assign clk_rise = rst_sync && (div == {1'b0, {SLOW{1'b1}}});
    assign clk_fall = rst_sync && (&div);

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                    rcnt <= '0;
      else if (clk_rise && !rcnt_full) rcnt <= rcnt + RW'(1);
    end

    // Release lands on a clk fall so clk-domain logic sees a full setup window.
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                     resetn <= 1'b0;
      else if (clk_fall && rcnt_full) resetn <= 1'b1;
    end
  end else begin : g_pass
    assign clk = CLK;

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)                    rcnt <= '0;
      else if (rst_sync && !rcnt_full) rcnt <= rcnt + RW'(1);
    end

    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)         resetn <= 1'b0;
      else if (rcnt_full) resetn <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clockworks.sv
// Scoreboard bench for clockworks: three parameterisations checked against an
// edge-count model of the release sequence under random reset pulses.
module tb_clockworks;

  logic CLK;
  logic RESET;

  clockworks_if sys2 ();
  clockworks_if sys1 ();
  clockworks_if sys0 ();

  clockworks #(.SLOW(2), .RST_CYCLES(4)) u_div2 (
    .CLK(CLK), .RESET(RESET), .clk(sys2.clk), .resetn(sys2.resetn));
  clockworks #(.SLOW(1), .RST_CYCLES(1)) u_div1 (
    .CLK(CLK), .RESET(RESET), .clk(sys1.clk), .resetn(sys1.resetn));
  clockworks #(.SLOW(0), .RST_CYCLES(3)) u_pass (
    .CLK(CLK), .RESET(RESET), .clk(sys0.clk), .resetn(sys0.resetn));

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct packed {
    logic c2, r2, c1, r1, r0;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  int unsigned n = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: behaviour as a function of CLK edges since RESET release.
  function automatic logic exp_clk(int unsigned e, int unsigned s);
    if (e < 2) return 1'b0;
    return ((e - 2) % (2 ** (s + 1))) >= (2 ** s);
  endfunction

  function automatic logic exp_rstn_div(int unsigned e, int unsigned s, int unsigned r);
    return e >= 2 + r * (2 ** (s + 1));
  endfunction

  function automatic logic exp_rstn_pass(int unsigned e, int unsigned r);
    return e >= 2 + r + 1;
  endfunction

  always @(negedge RESET) n = 0;

  always @(posedge CLK) begin
    exp_t e;
    if (!RESET) n = 0;
    else        n = n + 1;
    e.c2 = exp_clk(n, 2);
    e.r2 = exp_rstn_div(n, 2, 4);
    e.c1 = exp_clk(n, 1);
    e.r1 = exp_rstn_div(n, 1, 1);
    e.r0 = exp_rstn_pass(n, 3);
    sb.push_back(e);
    last = e;
  end

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      check("div2_clk",    sys2.clk,    e.c2);
      check("div2_resetn", sys2.resetn, e.r2);
      check("div1_clk",    sys1.clk,    e.c1);
      check("div1_resetn", sys1.resetn, e.r1);
      check("pass_resetn", sys0.resetn, e.r0);
      check("pass_clk_hi", sys0.clk,    CLK);
    end
  end

  always @(negedge CLK) begin
    #1;
    check("pass_clk_lo", sys0.clk, CLK);
  end

  task automatic release_reset();
    @(negedge CLK);
    #2;
    RESET = 1'b1;
  endtask

  // Called between CLK edges; outputs must collapse before the next edge.
  task automatic assert_async();
    RESET = 1'b0;
    #1;
    check("async_div2_clk",    sys2.clk,    1'b0);
    check("async_div2_resetn", sys2.resetn, 1'b0);
    check("async_div1_clk",    sys1.clk,    1'b0);
    check("async_div1_resetn", sys1.resetn, 1'b0);
    check("async_pass_resetn", sys0.resetn, 1'b0);
    check("async_pass_clk",    sys0.clk,    CLK);
  endtask

  task automatic long_reset(input int unsigned hold);
    assert_async();
    repeat (hold) @(posedge CLK);
    release_reset();
  endtask

  task automatic glitch_reset();
    assert_async();
    #($urandom_range(1, 3));
    RESET = 1'b1;
  endtask

  initial begin
    logic found;
    RESET = 1'b0;
    repeat (3) @(posedge CLK);
    release_reset();
    repeat (1040) @(posedge CLK);

    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(posedge CLK);
      #2;
      if (last.c2) found = 1'b1;
    end
    check("found_div2_clk_high", found, 1'b1);
    #1;
    long_reset(3);
    repeat (40) @(posedge CLK);

    @(posedge CLK);
    #3;
    glitch_reset();
    repeat (60) @(posedge CLK);

    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(1, 90)) @(posedge CLK);
      #($urandom_range(2, 4));
      if ($urandom_range(0, 1) == 0) glitch_reset();
      else                           long_reset($urandom_range(1, 4));
    end
    repeat (60) @(posedge CLK);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
